// File: rtl/datamemory_be.sv
// datamemory_be: byte-addressed data memory with byte/half/word/double
// loads and stores, per-lane byte enables, sign/zero extension, a registered
// one-cycle load path with rd_valid, and a registered misalignment flag.
// Optional feature macro: DATAMEM_RDW_BYPASS_EN
//   defined     -> a simultaneous load and store returns the post-write word
//   not defined -> read-first: a simultaneous load returns pre-write contents
// The storage array is not reset; a store coincident with rst is suppressed.
module datamemory_be #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            funct3,
  input  logic [DM_ADDRESS-1:0] a,
  input  logic [DATA_W-1:0]     wd,
  output logic [DATA_W-1:0]     rd,
  output logic                  rd_valid,
  output logic                  misaligned
);

  localparam int NB    = DATA_W / 8;
  localparam int OFS   = $clog2(NB);
  localparam int WA    = DM_ADDRESS - OFS;
  localparam int DEPTH = 1 << WA;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [WA-1:0]     idx;
  logic [OFS-1:0]    ofs;
  logic [3:0]        size_b;
  logic [6:0]        size_bits;
  logic              illegal;
  logic              bad;
  logic              wr_en;
  logic              ld_ok;
  logic [NB-1:0]     lane_ones;
  logic [NB-1:0]     lane_mask;
  logic [DATA_W-1:0] bit_mask;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] old_word;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] size_mask;
  logic [DATA_W-1:0] msb_mask;
  logic [DATA_W-1:0] ext;

  logic [DATA_W-1:0] rd_d, rd_q;
  logic              rd_valid_d, rd_valid_q;
  logic              misaligned_d, misaligned_q;

  assign idx = a[DM_ADDRESS-1:OFS];
  assign ofs = a[OFS-1:0];

  // Decode access size, legality and alignment of the current request
  always_comb begin
    size_b    = 4'd1 << funct3[1:0];
    size_bits = {size_b, 3'b000};
    illegal   = (funct3 == 3'b111)
             || ((DATA_W == 32) && (funct3[1:0] == 2'd3))
             || (funct3[2] && (int'(size_b) == NB));
    bad       = illegal || (|(ofs & OFS'(size_b - 4'd1)));
    wr_en     = MemWrite && !bad && !rst;
    ld_ok     = MemRead && !bad;
  end

  // Build lane mask and lane-aligned write data for a store
  always_comb begin
    lane_ones = '0;
    bit_mask  = '0;
    for (int l = 0; l < NB; l++) begin
      lane_ones[l] = (l < int'(size_b));
    end
    lane_mask = lane_ones << ofs;
    for (int l = 0; l < NB; l++) begin
      bit_mask[8*l +: 8] = {8{lane_mask[l]}};
    end
    wr_data = wd << {ofs, 3'b000};
  end

  // Select the word seen by a load: pre-write, or merged with a same-cycle store
  always_comb begin
    old_word = mem_q[idx];
`ifdef DATAMEM_RDW_BYPASS_EN
    rd_word = (MemWrite && !bad) ? ((old_word & ~bit_mask) | (wr_data & bit_mask))
                                 : old_word;
`else
    rd_word = old_word;
`endif
  end

  // Right-align the addressed bytes and sign- or zero-extend them
  always_comb begin
    shifted   = rd_word >> {ofs, 3'b000};
    // A shift by the full width yields zero, so the double/word-on-32 case
    // wraps to an all-ones mask as intended.
    size_mask = (DATA_W'(1) << size_bits) - DATA_W'(1);
    msb_mask  = size_mask ^ (size_mask >> 1);
    ext       = shifted & size_mask;
    if (!funct3[2] && (|(shifted & msb_mask))) begin
      ext = ext | ~size_mask;
    end
  end

  // Next-state for the registered outputs
  always_comb begin
    rd_d         = rd_q;
    rd_valid_d   = ld_ok;
    misaligned_d = bad && (MemRead || MemWrite);
    if (ld_ok) begin
      rd_d = ext;
    end
  end

  // Output registers, synchronously cleared by rst
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q         <= '0;
      rd_valid_q   <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      rd_q         <= rd_d;
      rd_valid_q   <= rd_valid_d;
      misaligned_q <= misaligned_d;
    end
  end

  // Byte-lane writable storage array
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int l = 0; l < NB; l++) begin
        if (lane_mask[l]) begin
          mem_q[idx][8*l +: 8] <= wr_data[8*l +: 8];
        end
      end
    end
  end

  assign rd         = rd_q;
  assign rd_valid   = rd_valid_q;
  assign misaligned = misaligned_q;

endmodule
